// File: rtl/serial_receiver_if.sv
// rtl/serial_receiver_if.sv - serial input and parallel output signal bundle for serial_receiver (ErrorCount present with SERIAL_RX_ERRCNT_EN)
interface serial_receiver_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  SerialIn;
    logic                  FrameActive;
    logic                  BitStrobe;
    logic [DATA_WIDTH-1:0] DataOut;
    logic                  DataValid;
    logic                  DataReady;
    logic                  RxBusy;
    logic                  FrameError;
    logic                  Overflow;
`ifdef SERIAL_RX_ERRCNT_EN
    logic [15:0]           ErrorCount;

    modport slave (
        input  SerialIn, FrameActive, BitStrobe, DataReady,
        output DataOut, DataValid, RxBusy, FrameError, Overflow, ErrorCount
    );

    modport master (
        output SerialIn, FrameActive, BitStrobe, DataReady,
        input  DataOut, DataValid, RxBusy, FrameError, Overflow, ErrorCount
    );
`else
    modport slave (
        input  SerialIn, FrameActive, BitStrobe, DataReady,
        output DataOut, DataValid, RxBusy, FrameError, Overflow
    );

    modport master (
        output SerialIn, FrameActive, BitStrobe, DataReady,
        input  DataOut, DataValid, RxBusy, FrameError, Overflow
    );
`endif
endinterface

// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - MSB-first serial deserializer with FWFT output FIFO; SERIAL_RX_ERRCNT_EN adds a saturating error counter
module serial_receiver #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    serial_receiver_if.slave   bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

    typedef enum logic {IDLE, RECEIVE} state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] sr_next;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic                  sample;
    logic                  word_done;
    logic                  frame_abort;
    logic [DATA_WIDTH-1:0] word;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW:0]           wr_ptr;
    logic [PW:0]           rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  frame_error_q;
    logic                  overflow_q;

    assign sample = bus.BitStrobe && bus.FrameActive;
    // The new bit enters at the LSB; the oldest bit falls off the MSB.
    assign word   = DATA_WIDTH'({sr, bus.SerialIn});

    // Receive FSM state, shift register and bit counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            sr    <= sr_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: shift on each sample, complete at the last bit, abort when the frame drops early.
    always_comb begin
        state_next  = state;
        sr_next     = sr;
        cnt_next    = cnt;
        word_done   = 1'b0;
        frame_abort = 1'b0;
        case (state)
            IDLE: begin
                if (sample) begin
                    sr_next    = word;
                    cnt_next   = CW'(1);
                    state_next = RECEIVE;
                end
            end
            RECEIVE: begin
                if (sample) begin
                    sr_next = word;
                    if (cnt == CW'(DATA_WIDTH - 1)) begin
                        word_done  = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end else if (!bus.FrameActive) begin
                    frame_abort = 1'b1;
                    cnt_next    = '0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop   = !empty && bus.DataReady;
    // A pop in the completion cycle frees the slot the new word needs.
    assign push  = word_done && (!full || pop);
    assign drop  = word_done && full && !pop;

    // FIFO storage and pointers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[PW-1:0]] <= word;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Error pulses are registered one edge after the triggering condition.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            frame_error_q <= frame_abort;
            overflow_q    <= drop;
        end
    end

`ifdef SERIAL_RX_ERRCNT_EN
    logic [15:0] err_cnt;

    // Abort and drop are mutually exclusive, so one increment per event is enough.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            err_cnt <= '0;
        end else if ((frame_abort || drop) && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign bus.ErrorCount = err_cnt;
`endif

    assign bus.DataOut    = mem[rd_ptr[PW-1:0]];
    assign bus.DataValid  = !empty;
    assign bus.RxBusy     = (state == RECEIVE);
    assign bus.FrameError = frame_error_q;
    assign bus.Overflow   = overflow_q;
endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - directed self-checking bench for serial_receiver (ErrorCount checks with SERIAL_RX_ERRCNT_EN)
module tb_serial_receiver;
    logic Clk = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;
    int   ovf_seen = 0;
    int   ferr_seen = 0;

    always #5 Clk = ~Clk;

    serial_receiver_if #(.DATA_WIDTH(32)) bus ();

    serial_receiver #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Pulse counters, sampled away from the active edge.
    always @(negedge Clk) begin
        if (bus.Overflow === 1'b1) ovf_seen++;
        if (bus.FrameError === 1'b1) ferr_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Reset           = 1'b1;
        bus.SerialIn    = 1'b0;
        bus.FrameActive = 1'b0;
        bus.BitStrobe   = 1'b0;
        bus.DataReady   = 1'b0;
        tick();
        tick();
        Reset     = 1'b0;
        ovf_seen  = 0;
        ferr_seen = 0;
    endtask

    // Sends w[hi] down to w[lo]; returns just after the edge sampling w[lo].
    task automatic send_bits(input logic [31:0] w, input int hi, input int lo, input int gap);
        for (int i = hi; i >= lo; i--) begin
            bus.SerialIn    = w[i];
            bus.FrameActive = 1'b1;
            bus.BitStrobe   = 1'b1;
            tick();
            bus.BitStrobe = 1'b0;
            if (i != lo) begin
                for (int g = 1; g < gap; g++) tick();
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge Clk);
        checks++; if (bus.DataOut !== 32'h0) begin errors++; $display("FAIL reset_dataout: got %h want 0", bus.DataOut); end
        checks++; if (bus.DataValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.DataValid); end
        checks++; if (bus.RxBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.RxBusy); end
        checks++; if ((bus.FrameError !== 1'b0) || (bus.Overflow !== 1'b0)) begin errors++; $display("FAIL reset_pulses: got ferr=%b ovf=%b want 0 0", bus.FrameError, bus.Overflow); end
`ifdef SERIAL_RX_ERRCNT_EN
        checks++; if (bus.ErrorCount !== 16'd0) begin errors++; $display("FAIL reset_errcnt: got %0d want 0", bus.ErrorCount); end
`endif
    endtask

    task automatic test_single();
        apply_reset();
        bus.DataReady = 1'b1;
        send_bits(32'hA5C3_0F81, 31, 31, 4);
        @(negedge Clk);
        checks++; if (bus.RxBusy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.RxBusy); end
        repeat (3) tick();
        send_bits(32'hA5C3_0F81, 30, 0, 4);
        bus.FrameActive = 1'b0;
        @(negedge Clk);
        checks++; if (bus.DataValid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.DataValid); end
        checks++; if (bus.DataOut !== 32'hA5C3_0F81) begin errors++; $display("FAIL single_data: got %h want a5c30f81", bus.DataOut); end
        checks++; if (bus.RxBusy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", bus.RxBusy); end
        tick();
        @(negedge Clk);
        checks++; if (bus.DataValid !== 1'b0) begin errors++; $display("FAIL single_popped: got %b want 0", bus.DataValid); end
        checks++; if ((ovf_seen != 0) || (ferr_seen != 0)) begin errors++; $display("FAIL single_pulses: got ovf=%0d ferr=%0d want 0 0", ovf_seen, ferr_seen); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int k = 1; k <= 5; k++) send_bits(32'(k), 31, 0, 1);
        bus.FrameActive = 1'b0;
        @(negedge Clk);
        checks++; if (bus.Overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", bus.Overflow); end
        checks++; if (bus.DataOut !== 32'h1) begin errors++; $display("FAIL ovf_head: got %h want 1", bus.DataOut); end
        tick();
        @(negedge Clk);
        checks++; if (bus.Overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %b want 0", bus.Overflow); end
        checks++; if ((ovf_seen != 1) || (ferr_seen != 0)) begin errors++; $display("FAIL ovf_count: got ovf=%0d ferr=%0d want 1 0", ovf_seen, ferr_seen); end
`ifdef SERIAL_RX_ERRCNT_EN
        checks++; if (bus.ErrorCount !== 16'd1) begin errors++; $display("FAIL ovf_errcnt: got %0d want 1", bus.ErrorCount); end
`endif
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            checks++; if ((bus.DataValid !== 1'b1) || (bus.DataOut !== 32'(k))) begin errors++; $display("FAIL ovf_drain: got v=%b d=%h want v=1 d=%h", bus.DataValid, bus.DataOut, 32'(k)); end
            bus.DataReady = 1'b1;
            tick();
            bus.DataReady = 1'b0;
        end
        @(negedge Clk);
        checks++; if (bus.DataValid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", bus.DataValid); end
    endtask

    task automatic test_abort();
        apply_reset();
        bus.DataReady = 1'b1;
        send_bits(32'h1234_5678, 31, 15, 2);
        bus.FrameActive = 1'b0;
        tick();
        @(negedge Clk);
        checks++; if (bus.FrameError !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b want 1", bus.FrameError); end
        checks++; if ((bus.RxBusy !== 1'b0) || (bus.DataValid !== 1'b0)) begin errors++; $display("FAIL abort_state: got busy=%b valid=%b want 0 0", bus.RxBusy, bus.DataValid); end
        tick();
        @(negedge Clk);
        checks++; if (bus.FrameError !== 1'b0) begin errors++; $display("FAIL abort_one_cycle: got %b want 0", bus.FrameError); end
        send_bits(32'hDEAD_BEEF, 31, 0, 2);
        bus.FrameActive = 1'b0;
        @(negedge Clk);
        checks++; if ((bus.DataValid !== 1'b1) || (bus.DataOut !== 32'hDEAD_BEEF)) begin errors++; $display("FAIL abort_next: got v=%b d=%h want v=1 d=deadbeef", bus.DataValid, bus.DataOut); end
        checks++; if ((ferr_seen != 1) || (ovf_seen != 0)) begin errors++; $display("FAIL abort_count: got ferr=%0d ovf=%0d want 1 0", ferr_seen, ovf_seen); end
`ifdef SERIAL_RX_ERRCNT_EN
        checks++; if (bus.ErrorCount !== 16'd1) begin errors++; $display("FAIL abort_errcnt: got %0d want 1", bus.ErrorCount); end
`endif
    endtask

    task automatic test_simul_pop();
        logic [31:0] exp_words [4];
        exp_words = '{32'h2, 32'h3, 32'h4, 32'h6};
        apply_reset();
        for (int k = 1; k <= 4; k++) send_bits(32'(k), 31, 0, 1);
        send_bits(32'h0000_0006, 31, 1, 1);
        bus.SerialIn  = 1'b0;
        bus.BitStrobe = 1'b1;
        bus.DataReady = 1'b1;
        tick();
        bus.BitStrobe   = 1'b0;
        bus.DataReady   = 1'b0;
        bus.FrameActive = 1'b0;
        @(negedge Clk);
        checks++; if (bus.Overflow !== 1'b0) begin errors++; $display("FAIL simpop_no_ovf: got %b want 0", bus.Overflow); end
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            checks++; if ((bus.DataValid !== 1'b1) || (bus.DataOut !== exp_words[k])) begin errors++; $display("FAIL simpop_drain: got v=%b d=%h want v=1 d=%h", bus.DataValid, bus.DataOut, exp_words[k]); end
            bus.DataReady = 1'b1;
            tick();
            bus.DataReady = 1'b0;
        end
        @(negedge Clk);
        checks++; if ((bus.DataValid !== 1'b0) || (ovf_seen != 0)) begin errors++; $display("FAIL simpop_end: got valid=%b ovf=%0d want 0 0", bus.DataValid, ovf_seen); end
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        send_bits(32'h11, 31, 0, 1);
        send_bits(32'h22, 31, 0, 1);
        send_bits(32'hCAFE_F00D, 31, 12, 1);
        @(negedge Clk);
        checks++; if ((bus.DataValid !== 1'b1) || (bus.RxBusy !== 1'b1)) begin errors++; $display("FAIL midrst_pre: got valid=%b busy=%b want 1 1", bus.DataValid, bus.RxBusy); end
        Reset           = 1'b1;
        bus.FrameActive = 1'b0;
        tick();
        Reset = 1'b0;
        @(negedge Clk);
        checks++; if ((bus.DataValid !== 1'b0) || (bus.RxBusy !== 1'b0) || (bus.FrameError !== 1'b0)) begin errors++; $display("FAIL midrst_post: got valid=%b busy=%b ferr=%b want 0 0 0", bus.DataValid, bus.RxBusy, bus.FrameError); end
        tick();
        @(negedge Clk);
        checks++; if ((ferr_seen != 0) || (ovf_seen != 0)) begin errors++; $display("FAIL midrst_pulses: got ferr=%0d ovf=%0d want 0 0", ferr_seen, ovf_seen); end
        bus.DataReady = 1'b1;
        send_bits(32'h8000_0001, 31, 0, 2);
        bus.FrameActive = 1'b0;
        @(negedge Clk);
        checks++; if ((bus.DataValid !== 1'b1) || (bus.DataOut !== 32'h8000_0001)) begin errors++; $display("FAIL midrst_next: got v=%b d=%h want v=1 d=80000001", bus.DataValid, bus.DataOut); end
    endtask

    task automatic test_idle_strobes();
        int bad;
        bad = 0;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            bus.SerialIn  = i[0];
            bus.BitStrobe = 1'b1;
            tick();
            bus.BitStrobe = 1'b0;
            @(negedge Clk);
            if ((bus.RxBusy !== 1'b0) || (bus.DataValid !== 1'b0) || (bus.FrameError !== 1'b0) || (bus.Overflow !== 1'b0)) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_strobes: got %0d disturbed cycles want 0", bad); end
        bus.DataReady = 1'b1;
        send_bits(32'h0F0F_0F0F, 31, 0, 1);
        bus.FrameActive = 1'b0;
        @(negedge Clk);
        checks++; if ((bus.DataValid !== 1'b1) || (bus.DataOut !== 32'h0F0F_0F0F)) begin errors++; $display("FAIL idle_next: got v=%b d=%h want v=1 d=0f0f0f0f", bus.DataValid, bus.DataOut); end
`ifdef SERIAL_RX_ERRCNT_EN
        checks++; if (bus.ErrorCount !== 16'd0) begin errors++; $display("FAIL idle_errcnt: got %0d want 0", bus.ErrorCount); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_abort();
        test_simul_pop();
        test_reset_midframe();
        test_idle_strobes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
